// File: rtl/sudoku_pkg.sv
// Shared state codes and checker status codes for the Sudoku game controller.
package sudoku_pkg;

    typedef enum logic [2:0] {
        RECV_ROW  = 3'd0,
        RECV_COL  = 3'd1,
        CHK_POS   = 3'd2,
        RECV_VAL  = 3'd3,
        CHK_GAME  = 3'd4,
        GAME_WON  = 3'd5,
        GAME_LOST = 3'd6
    } state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_DONE = 2'b01;
    localparam logic [1:0] ST_BAD  = 2'b10;
    localparam logic [1:0] ST_RSVD = 2'b11;

endpackage

// File: rtl/sudoku_idle_timer.sv
// Idle down-counter for partial-entry abort; expire pulses on the last idle cycle.
module sudoku_idle_timer #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= TC_LOAD;
        end else if (clear || !run || cnt == '0) begin
            cnt <= TC_LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = run && !clear && (cnt == '0);

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Game-flow controller: row/col/val entry, checker handshakes, move/error accounting.
// Optional idle abort of partial entries when SUDOKU_TIMEOUT_EN is defined.
//   state     | meaning
//   RECV_ROW  | waiting for row key
//   RECV_COL  | waiting for column key
//   CHK_POS   | position checker request in flight
//   RECV_VAL  | waiting for value key
//   CHK_GAME  | game checker request in flight
//   GAME_WON  | terminal, board complete
//   GAME_LOST | terminal, error budget spent
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int N          = 9,
    parameter int VW         = 4,
    parameter int MAX_ERRORS = 3,
    parameter int MOVE_W     = 8
`ifdef SUDOKU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 50_000_000
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key_valid,
    input  logic [VW-1:0]     key_value,
    input  logic              clr,
    input  logic              new_game,
    input  logic              pos_ack,
    input  logic              pos_ok,
    input  logic              game_ack,
    input  logic [1:0]        game_status,
    output logic [2:0]        state,
    output logic [VW-1:0]     row,
    output logic [VW-1:0]     col,
    output logic [VW-1:0]     val,
    output logic              pos_req,
    output logic              game_req,
    output logic              board_we,
    output logic              key_reject,
    output logic [MOVE_W-1:0] move_cnt,
    output logic [7:0]        err_cnt,
    output logic              proto_err,
    output logic              timeout
);

    localparam logic [VW-1:0] N_KEY   = VW'(N);
    localparam logic [7:0]    ERR_MAX = 8'(MAX_ERRORS);

    state_t state_q, state_d;
    logic   key_in_range, key_acc, in_recv, timeout_hit, abort_entry;

    assign key_in_range = (key_value != '0) && (key_value <= N_KEY);
    assign key_acc      = key_valid && key_in_range;
    assign in_recv      = (state_q == RECV_ROW) || (state_q == RECV_COL) || (state_q == RECV_VAL);
    assign abort_entry  = clr || timeout_hit;

`ifdef SUDOKU_TIMEOUT_EN
    logic idle_run;
    assign idle_run = (state_q == RECV_COL) || (state_q == RECV_VAL);

    sudoku_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk    (clk),
        .rstn   (rstn),
        .run    (idle_run),
        .clear  (key_valid),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= RECV_ROW;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV_ROW:  if (key_acc) state_d = RECV_COL;
            RECV_COL:  if (abort_entry) state_d = RECV_ROW;
                       else if (key_acc) state_d = CHK_POS;
            CHK_POS:   if (pos_ack) state_d = pos_ok ? RECV_VAL : RECV_ROW;
            RECV_VAL:  if (abort_entry) state_d = RECV_ROW;
                       else if (key_acc) state_d = CHK_GAME;
            CHK_GAME: begin
                if (game_ack) begin
                    case (game_status)
                        ST_OK:   state_d = RECV_ROW;
                        ST_DONE: state_d = GAME_WON;
                        ST_BAD:  state_d = (err_cnt + 8'd1 == ERR_MAX) ? GAME_LOST : RECV_ROW;
                        default: state_d = CHK_GAME;
                    endcase
                end
            end
            GAME_WON, GAME_LOST: if (new_game) state_d = RECV_ROW;
            default:   state_d = RECV_ROW;
        endcase
    end

    always_comb begin
        pos_req    = (state_q == CHK_POS);
        game_req   = (state_q == CHK_GAME);
        key_reject = key_valid && in_recv && !key_in_range;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row       <= '0;
            col       <= '0;
            val       <= '0;
            move_cnt  <= '0;
            err_cnt   <= '0;
            proto_err <= 1'b0;
            board_we  <= 1'b0;
        end else begin
            board_we <= 1'b0;
            case (state_q)
                RECV_ROW: if (key_acc) row <= key_value;
                RECV_COL, RECV_VAL: begin
                    if (abort_entry) begin
                        row <= '0;
                        col <= '0;
                        val <= '0;
                    end else if (key_acc) begin
                        if (state_q == RECV_COL) col <= key_value;
                        else                     val <= key_value;
                    end
                end
                CHK_GAME: begin
                    if (game_ack) begin
                        case (game_status)
                            ST_OK, ST_DONE: begin
                                board_we <= 1'b1;
                                if (move_cnt != '1) move_cnt <= move_cnt + 1'b1;
                            end
                            ST_BAD:  err_cnt   <= err_cnt + 8'd1;
                            default: proto_err <= 1'b1;
                        endcase
                    end
                end
                GAME_WON, GAME_LOST: begin
                    if (new_game) begin
                        row       <= '0;
                        col       <= '0;
                        val       <= '0;
                        move_cnt  <= '0;
                        err_cnt   <= '0;
                        proto_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign timeout = timeout_hit;

endmodule
